// File: rtl/decode_hazard_stage_pkg.sv
// Shared definitions for the decode/hazard stage: RV32 opcode constants,
// 6-bit ALU operation codes, immediate-format and stage-state enums, the
// default bubble instruction, and a helper mapping an opcode to its
// immediate format.
package decode_hazard_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [5:0] ALU_ADD   = 6'd0;
  localparam logic [5:0] ALU_SUB   = 6'd1;
  localparam logic [5:0] ALU_SLL   = 6'd2;
  localparam logic [5:0] ALU_SLT   = 6'd3;
  localparam logic [5:0] ALU_SLTU  = 6'd4;
  localparam logic [5:0] ALU_XOR   = 6'd5;
  localparam logic [5:0] ALU_SRL   = 6'd6;
  localparam logic [5:0] ALU_SRA   = 6'd7;
  localparam logic [5:0] ALU_OR    = 6'd8;
  localparam logic [5:0] ALU_AND   = 6'd9;
  localparam logic [5:0] ALU_PASSB = 6'd10;
  localparam logic [5:0] ALU_EQ    = 6'd11;
  localparam logic [5:0] ALU_NE    = 6'd12;
  localparam logic [5:0] ALU_LT    = 6'd13;
  localparam logic [5:0] ALU_GE    = 6'd14;
  localparam logic [5:0] ALU_LTU   = 6'd15;
  localparam logic [5:0] ALU_GEU   = 6'd16;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef enum logic {ST_RUN, ST_STALL} stage_state_e;

  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opc);
    case (opc)
      OPC_OPIMM, OPC_LOAD, OPC_JALR: return IMM_I;
      OPC_STORE:                     return IMM_S;
      OPC_BRANCH:                    return IMM_B;
      OPC_LUI, OPC_AUIPC:            return IMM_U;
      OPC_JAL:                       return IMM_J;
      default:                       return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: assembles the sign-extended immediate of the given
// format from instruction bits [31:7].
//   ir_i  : instruction bits [31:7] (opcode bits are not needed here)
//   fmt_i : immediate format
//   imm_o : XLEN-bit sign-extended immediate (0 for IMM_NONE)
module imm_gen
  import decode_hazard_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     ir_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] raw;

  always_comb begin
    raw = '0;
    case (fmt_i)
      IMM_I:   raw = {{20{ir_i[31]}}, ir_i[31:20]};
      IMM_S:   raw = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
      IMM_B:   raw = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
      IMM_U:   raw = {ir_i[31:12], 12'b0};
      IMM_J:   raw = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
      default: raw = '0;
    endcase
  end

  // The 32-bit immediates are already sign-extended; widen further by sign.
  assign imm_o = XLEN'($signed(raw));

endmodule

// File: rtl/decode_hazard_stage.sv
// Decode / hazard stage: decodes the fetched instruction, reads the
// register file combinationally, forwards MEM/WB results, inserts one
// bubble per load-use hazard and registers the EX operands.
//   clk, reset              : clock, synchronous active-high reset
//   in_valid/in_ready       : fetch-side handshake; ir_in, pc_in payload
//   rs1/rs2_addr, _data     : register-file read port (same cycle)
//   ex_*, mem_*, wb_*       : downstream destination / writeback info
//   flush                   : kill of the instruction in this stage
//   out_valid/out_ready     : EX-side handshake
//   ir/pc/x/y/md/br_target_out, alu_sel_out : registered EX operands
module decode_hazard_stage
  import decode_hazard_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(NOP_WORD_DEFAULT),
  localparam int             REGW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] ir_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [REGW-1:0] rs1_addr,
  output logic [REGW-1:0] rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_wen,
  input  logic            ex_is_load,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_wen,
  input  logic [XLEN-1:0] mem_result,
  input  logic [REGW-1:0] wb_rd,
  input  logic            wb_wen,
  input  logic [XLEN-1:0] wb_result,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ir_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] x_out,
  output logic [XLEN-1:0] y_out,
  output logic [XLEN-1:0] md_out,
  output logic [XLEN-1:0] br_target_out,
  output logic [5:0]      alu_sel_out
);

  stage_state_e state_q, state_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_b5;
  imm_fmt_e        imm_fmt;
  logic [XLEN-1:0] imm;
  logic            uses_rs1, uses_rs2, x_is_pc, y_is_imm;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic [5:0]      alu_sel;
  logic            hazard, load_en;

  logic            valid_q;
  logic [XLEN-1:0] ir_q, pc_q, x_q, y_q, md_q, br_q;
  logic [5:0]      alu_q;

  assign opcode    = ir_in[6:0];
  assign funct3    = ir_in[14:12];
  assign funct7_b5 = ir_in[30];
  assign rs1_addr  = ir_in[15 +: REGW];
  assign rs2_addr  = ir_in[20 +: REGW];
  assign imm_fmt   = imm_fmt_of(opcode);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .ir_i  (ir_in[31:7]),
    .fmt_i (imm_fmt),
    .imm_o (imm)
  );

  // Which sources the opcode really reads; only these can raise a hazard.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_OP, OPC_STORE, OPC_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_OPIMM, OPC_LOAD, OPC_JALR: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign x_is_pc  = (opcode == OPC_AUIPC) || (opcode == OPC_JAL);
  assign y_is_imm = (imm_fmt != IMM_NONE) && (imm_fmt != IMM_B);

  // MEM is younger than WB, so it wins when both target the same register.
  always_comb begin
    rs1_fwd = rs1_data;
    if (mem_wen && mem_rd != '0 && mem_rd == rs1_addr)    rs1_fwd = mem_result;
    else if (wb_wen && wb_rd != '0 && wb_rd == rs1_addr)  rs1_fwd = wb_result;
    rs2_fwd = rs2_data;
    if (mem_wen && mem_rd != '0 && mem_rd == rs2_addr)    rs2_fwd = mem_result;
    else if (wb_wen && wb_rd != '0 && wb_rd == rs2_addr)  rs2_fwd = wb_result;
  end

  always_comb begin
    alu_sel = ALU_ADD;
    case (opcode)
      OPC_OP, OPC_OPIMM: begin
        case (funct3)
          3'd0: alu_sel = (opcode == OPC_OP && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'd1: alu_sel = ALU_SLL;
          3'd2: alu_sel = ALU_SLT;
          3'd3: alu_sel = ALU_SLTU;
          3'd4: alu_sel = ALU_XOR;
          3'd5: alu_sel = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'd6: alu_sel = ALU_OR;
          default: alu_sel = ALU_AND;
        endcase
      end
      OPC_BRANCH: begin
        case (funct3)
          3'd0: alu_sel = ALU_EQ;
          3'd1: alu_sel = ALU_NE;
          3'd4: alu_sel = ALU_LT;
          3'd5: alu_sel = ALU_GE;
          3'd6: alu_sel = ALU_LTU;
          3'd7: alu_sel = ALU_GEU;
          default: alu_sel = ALU_ADD;
        endcase
      end
      OPC_LUI: alu_sel = ALU_PASSB;
      default: alu_sel = ALU_ADD;
    endcase
  end

  // The check is masked in STALL so exactly one bubble is inserted per load.
  assign hazard = (state_q == ST_RUN) && in_valid && ex_is_load && ex_wen &&
                  (ex_rd != '0) &&
                  ((uses_rs1 && ex_rd == rs1_addr) || (uses_rs2 && ex_rd == rs2_addr));
  assign load_en  = (out_ready || !valid_q) && !flush;
  assign in_ready = load_en && !hazard && !reset;

  always_comb begin
    state_d = ST_RUN;
    if (load_en && hazard) state_d = ST_STALL;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ir_q    <= NOP_WORD;
      pc_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      md_q    <= '0;
      br_q    <= '0;
      alu_q   <= ALU_ADD;
    end else if (flush || (load_en && !(in_valid && !hazard))) begin
      // Flush, load-use bubble, or nothing offered: issue a NOP.
      valid_q <= 1'b0;
      ir_q    <= NOP_WORD;
      alu_q   <= ALU_ADD;
    end else if (load_en) begin
      valid_q <= 1'b1;
      ir_q    <= ir_in;
      pc_q    <= pc_in;
      x_q     <= x_is_pc ? pc_in : rs1_fwd;
      y_q     <= y_is_imm ? imm : rs2_fwd;
      md_q    <= rs2_fwd;
      br_q    <= pc_in + imm;
      alu_q   <= alu_sel;
    end
  end

  assign out_valid     = valid_q;
  assign ir_out        = ir_q;
  assign pc_out        = pc_q;
  assign x_out         = x_q;
  assign y_out         = y_q;
  assign md_out        = md_q;
  assign br_target_out = br_q;
  assign alu_sel_out   = alu_q;

endmodule

// File: tb/tb_decode_hazard_stage.sv
// Bench for decode_hazard_stage: directed scenarios followed by random
// traffic, all checked against an instruction-level reference model.
module tb_decode_hazard_stage;
  import decode_hazard_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, ex_wen, ex_is_load, mem_wen, wb_wen, flush;
  logic        out_valid, out_ready;
  logic [31:0] ir_in, pc_in, rs1_data, rs2_data, mem_result, wb_result;
  logic [4:0]  rs1_addr, rs2_addr, ex_rd, mem_rd, wb_rd;
  logic [31:0] ir_out, pc_out, x_out, y_out, md_out, br_target_out;
  logic [5:0]  alu_sel_out;

  always #5 clk = ~clk;

  decode_hazard_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ir_in(ir_in), .pc_in(pc_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_rd(ex_rd), .ex_wen(ex_wen),
    .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_wen(mem_wen),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_result(wb_result),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .ir_out(ir_out),
    .pc_out(pc_out), .x_out(x_out), .y_out(y_out), .md_out(md_out),
    .br_target_out(br_target_out), .alu_sel_out(alu_sel_out)
  );

  typedef struct {
    logic        v;
    logic [31:0] ir, pc, x, y, md, br;
    logic [5:0]  alu;
  } out_t;

  out_t        exp_o, nxt_o;
  bit          stall_m, nstall_m;
  logic        exp_in_ready;
  logic [31:0] rf [32];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---- instruction-level reference model ----
  function automatic logic [31:0] imm_of(input logic [31:0] ir);
    case (ir[6:0])
      7'h13, 7'h03, 7'h67: return 32'($signed(ir) >>> 20);
      7'h23: return (32'($signed(ir) >>> 25) << 5) | 32'(ir[11:7]);
      7'h63: return (32'($signed(ir) >>> 31) << 12) | (32'(ir[7]) << 11) |
                    (32'(ir[30:25]) << 5) | (32'(ir[11:8]) << 1);
      7'h37, 7'h17: return ir & 32'hFFFF_F000;
      7'h6F: return (32'($signed(ir) >>> 31) << 20) | (32'(ir[19:12]) << 12) |
                    (32'(ir[20]) << 11) | (32'(ir[30:21]) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic logic [5:0] alu_of(input logic [31:0] ir);
    logic [5:0] arith [8];
    logic [5:0] brn   [8];
    logic [2:0] f3;
    arith = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    brn   = '{ALU_EQ, ALU_NE, ALU_ADD, ALU_ADD, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU};
    f3 = ir[14:12];
    case (ir[6:0])
      7'h33: begin
        if (ir[30] && f3 == 3'd0) return ALU_SUB;
        if (ir[30] && f3 == 3'd5) return ALU_SRA;
        return arith[f3];
      end
      7'h13: return (ir[30] && f3 == 3'd5) ? ALU_SRA : arith[f3];
      7'h63: return brn[f3];
      7'h37: return ALU_PASSB;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rfv);
    if (mem_wen && mem_rd != 0 && mem_rd == rs) return mem_result;
    if (wb_wen && wb_rd != 0 && wb_rd == rs)    return wb_result;
    return rfv;
  endfunction

  // Predict in_ready for this cycle and the register contents after the edge.
  task automatic model_eval();
    logic [6:0] op;
    logic [4:0] r1, r2;
    bit         ld_en, hz;
    op = ir_in[6:0];
    r1 = ir_in[19:15];
    r2 = ir_in[24:20];
    ld_en = (out_ready || !exp_o.v) && !flush;
    hz = !stall_m && in_valid && ex_is_load && ex_wen && ex_rd != 0 &&
         ((reads_rs1(op) && ex_rd == r1) || (reads_rs2(op) && ex_rd == r2));
    exp_in_ready = reset ? 1'b0 : (ld_en && !hz);
    nxt_o    = exp_o;
    nstall_m = 1'b0;
    if (reset) begin
      nxt_o = '{v: 1'b0, ir: 32'h13, pc: 0, x: 0, y: 0, md: 0, br: 0, alu: ALU_ADD};
    end else if (ld_en && in_valid && !hz) begin
      nxt_o.v   = 1'b1;
      nxt_o.ir  = ir_in;
      nxt_o.pc  = pc_in;
      nxt_o.x   = (op == 7'h17 || op == 7'h6F) ? pc_in : fwd(r1, rs1_data);
      nxt_o.y   = (op inside {7'h13, 7'h03, 7'h67, 7'h23, 7'h37, 7'h17, 7'h6F}) ?
                  imm_of(ir_in) : fwd(r2, rs2_data);
      nxt_o.md  = fwd(r2, rs2_data);
      nxt_o.br  = pc_in + imm_of(ir_in);
      nxt_o.alu = alu_of(ir_in);
    end else if (flush || ld_en) begin
      nxt_o.v   = 1'b0;
      nxt_o.ir  = 32'h13;
      nxt_o.alu = ALU_ADD;
      nstall_m  = ld_en && hz;
    end
  endtask

  task automatic check_outs();
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_o.v});
    chk("ir_out", ir_out, exp_o.ir);
    chk("alu_sel_out", {26'b0, alu_sel_out}, {26'b0, exp_o.alu});
    if (exp_o.v) begin
      chk("pc_out", pc_out, exp_o.pc);
      chk("x_out", x_out, exp_o.x);
      chk("y_out", y_out, exp_o.y);
      chk("md_out", md_out, exp_o.md);
      chk("br_target_out", br_target_out, exp_o.br);
    end
  endtask

  // Inputs are set just after a rising edge; check combinational outputs
  // mid-cycle, advance one edge, then check the registered outputs.
  task automatic step();
    rs1_data = rf[ir_in[19:15]];
    rs2_data = rf[ir_in[24:20]];
    #2;
    model_eval();
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_in_ready});
    chk("rs1_addr", {27'b0, rs1_addr}, {27'b0, ir_in[19:15]});
    chk("rs2_addr", {27'b0, rs2_addr}, {27'b0, ir_in[24:20]});
    if (in_valid && exp_in_ready)
      $display("TXN cyc=%0d ir=%h pc=%h", cyc, ir_in, pc_in);
    @(posedge clk);
    exp_o   = nxt_o;
    stall_m = nstall_m;
    cyc++;
    #1;
    check_outs();
  endtask

  task automatic clear_side();
    ex_rd = 0; ex_wen = 0; ex_is_load = 0;
    mem_rd = 0; mem_wen = 0; mem_result = 0;
    wb_rd = 0; wb_wen = 0; wb_result = 0;
    flush = 0;
  endtask

  logic [31:0] held_ir;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom();
    exp_o = '{v: 1'b0, ir: 32'h13, pc: 0, x: 0, y: 0, md: 0, br: 0, alu: ALU_ADD};
    reset = 1; in_valid = 0; ir_in = 32'h13; pc_in = 0; out_ready = 1;
    clear_side();
    @(posedge clk); #1;

    // Reset: in_ready low while asserted, all outputs at reset values.
    step(); step();
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_ir", ir_out, 32'h13);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_x", x_out, 32'h0);
    chk("rst_y", y_out, 32'h0);
    chk("rst_md", md_out, 32'h0);
    chk("rst_br", br_target_out, 32'h0);
    chk("rst_alu", {26'b0, alu_sel_out}, {26'b0, ALU_ADD});
    reset = 0;

    // ADDI x1,x0,5 at 0x100.
    in_valid = 1; ir_in = 32'h0050_0093; pc_in = 32'h100;
    step();
    chk("addi_valid", {31'b0, out_valid}, 32'h1);
    chk("addi_y", y_out, 32'h5);
    chk("addi_x", x_out, rf[0]);
    chk("addi_br", br_target_out, 32'h105);

    // Load-use: exactly one bubble, then the ADD issues.
    ex_is_load = 1; ex_wen = 1; ex_rd = 3;
    ir_in = 32'h0021_8233; pc_in = 32'h104;
    step();
    chk("lu_bubble_valid", {31'b0, out_valid}, 32'h0);
    chk("lu_bubble_ir", ir_out, 32'h13);
    step();
    chk("lu_issue_valid", {31'b0, out_valid}, 32'h1);
    chk("lu_issue_ir", ir_out, 32'h0021_8233);
    clear_side();

    // Forwarding: MEM beats WB; without MEM, WB; without both, register file.
    mem_wen = 1; mem_rd = 2; mem_result = 32'hAA;
    wb_wen = 1;  wb_rd = 2;  wb_result = 32'hBB;
    ir_in = 32'h0021_02B3; pc_in = 32'h108;
    step();
    chk("fwd_mem_x", x_out, 32'hAA);
    chk("fwd_mem_y", y_out, 32'hAA);
    mem_rd = 0;
    step();
    chk("fwd_wb_x", x_out, 32'hBB);
    wb_rd = 0;
    step();
    chk("fwd_rf_y", y_out, rf[2]);
    clear_side();

    // Flush during STALL: no issue, and RUN state re-detects the hazard.
    ex_is_load = 1; ex_wen = 1; ex_rd = 3;
    ir_in = 32'h0021_8233; pc_in = 32'h10C;
    step();
    flush = 1;
    step();
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    flush = 0;
    step();
    chk("flush_rerun_bubble", {31'b0, out_valid}, 32'h0);
    clear_side();
    step();
    chk("flush_after_issue", ir_out, 32'h0021_8233);

    // Backpressure for three cycles, then release.
    held_ir = ir_out;
    out_ready = 0; ir_in = 32'h0050_0093; pc_in = 32'h200;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_ir", ir_out, held_ir);
    end
    out_ready = 1;
    step();
    chk("bp_release_ir", ir_out, 32'h0050_0093);

    // BEQ -8 at pc 4 wraps.
    ir_in = 32'hFE20_8CE3; pc_in = 32'h4;
    step();
    chk("beq_wrap", br_target_out, 32'hFFFF_FFFC);

    // Random traffic with small register numbers to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      logic [6:0]  ops [10];
      logic [31:0] r;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
      r = $urandom();
      ir_in = {r[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               r[14:7], ops[$urandom_range(0, 9)]};
      pc_in      = $urandom();
      in_valid   = ($urandom_range(0, 9) < 8);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      reset      = ($urandom_range(0, 49) == 0);
      ex_is_load = $urandom_range(0, 1);
      ex_wen     = ($urandom_range(0, 3) != 0);
      ex_rd      = 5'($urandom_range(0, 3));
      mem_wen    = $urandom_range(0, 1);
      mem_rd     = 5'($urandom_range(0, 3));
      mem_result = $urandom();
      wb_wen     = $urandom_range(0, 1);
      wb_rd      = 5'($urandom_range(0, 3));
      wb_result  = $urandom();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_hazard_stage.md
DECODE_HAZARD_STAGE -- requirements
Module: decode_hazard_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and instruction width.
REQ-002 SHALL have parameter NREG, default 32, architectural register count; REGW = clog2(NREG).
REQ-003 SHALL have parameter NOP_WORD, default 32'h0000_0013, bubble instruction.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 in_valid / in_ready  in / out  1 / 1  fetch-side handshake.
REQ-007 ir_in, pc_in  in  XLEN each  instruction and its PC.
REQ-008 rs1_addr, rs2_addr  out  REGW each  combinational register-file read addresses (ir_in[19:15], ir_in[24:20]).
REQ-009 rs1_data, rs2_data  in  XLEN each  register-file read data, same cycle.
REQ-010 ex_rd, ex_wen, ex_is_load  in  REGW/1/1  destination info of instruction currently in EX.
REQ-011 mem_rd, mem_wen, mem_result  in  REGW/1/XLEN  MEM-stage writeback info.
REQ-012 wb_rd, wb_wen, wb_result  in  REGW/1/XLEN  WB-stage writeback info.
REQ-013 flush  in  1  branch-mispredict kill.
REQ-014 out_valid / out_ready  out / in  1 / 1  EX-side handshake.
REQ-015 ir_out, pc_out, x_out, y_out, md_out, br_target_out  out  XLEN each  registered EX operands.
REQ-016 alu_sel_out  out  6  registered ALU operation code.

Function
REQ-017 Output register SHALL load when (out_ready or !out_valid) and no flush; otherwise hold all outputs.
REQ-018 in_ready SHALL = load-enable of REQ-017 and not hazard; transfer occurs when in_valid and in_ready.
REQ-019 Hazard SHALL = in_valid, ex_is_load, ex_wen, ex_rd != 0, and ex_rd equals a source register the opcode actually reads.
REQ-020 On hazard with load-enable, SHALL load bubble: out_valid=0, ir_out=NOP_WORD, alu_sel_out=ADD; ir_in held upstream.
REQ-021 FSM states RUN, STALL: RUN->STALL on hazard bubble; STALL->RUN next cycle unconditionally (one bubble per load-use); in STALL the hazard check SHALL be suppressed.
REQ-022 Operand forwarding per source: MEM match (wen, rd!=0, rd==rs) first, then WB match, then register-file data.
REQ-023 x_out SHALL = pc_in for AUIPC/JAL, else forwarded rs1.
REQ-024 y_out SHALL = immediate for I/S/U/J-type and loads/stores, else forwarded rs2.
REQ-025 md_out SHALL = forwarded rs2 always.
REQ-026 Immediates sign-extended to XLEN from I, S, B, U, J formats selected by ir_in[6:0]; unknown opcode -> immediate 0.
REQ-027 br_target_out SHALL = pc_in + immediate, modulo 2^XLEN (wrap, no carry out).
REQ-028 alu_sel_out SHALL be decoded from opcode, funct3, funct7[5]; unknown opcode -> ADD code.
REQ-029 Flush SHALL dominate: next cycle out_valid=0, ir_out=NOP_WORD, state=RUN, in_ready=0 during flush cycle.
REQ-030 Latency: accepted instruction appears on outputs exactly one cycle after transfer.
REQ-031 Simultaneous hazard and out_ready=0 with out_valid=1: SHALL hold outputs; hazard re-evaluated next cycle.

Reset
REQ-032 On reset: out_valid=0, ir_out=NOP_WORD, pc_out/x_out/y_out/md_out/br_target_out=0, alu_sel_out=ADD, state=RUN.
REQ-033 Reset SHALL take priority over flush and handshake; in_ready=0 while reset asserted.

Structure
REQ-034 Shared package SHALL hold opcode constants, ALU operation codes (6-bit), immediate-format enum, NOP_WORD default.
REQ-035 Immediate generation SHALL be sub-module imm_gen (ir, format -> XLEN immediate); all else inline.

Verification
REQ-036 ADDI x1,x0,5 (0x00500093) at pc 0x100, out_ready=1 -> next cycle out_valid=1, y_out=5, x_out=rs1_data, br_target_out=0x105.
REQ-037 ex_is_load=1, ex_rd=3, ADD x4,x3,x2 -> exactly one bubble (out_valid=0, ir_out=0x13), ADD issues following cycle.
REQ-038 mem_rd=2 mem_result=0xAA, wb_rd=2 wb_result=0xBB, ADD x5,x2,x2 -> x_out=y_out=0xAA; with mem_rd=0 forwarding suppressed.
REQ-039 flush asserted during STALL -> next cycle out_valid=0, state RUN, stalled instruction not issued.
REQ-040 out_ready=0 for 3 cycles with valid output -> outputs stable, in_ready=0; release -> pending instruction advances.
REQ-041 BEQ with offset -8 at pc 0x4 -> br_target_out=0xFFFF_FFFC (wrap).
